// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin front end that lets two requesters share one
// memory controller. Each transaction is one command pulse to the controller,
// a fixed write occupancy or a bounded wait for read data, then a one-cycle
// completion pulse back to the granted requester.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// S_IDLE    | no transaction; arbitrate any pending request on the next edge
// S_ISSUE   | single cycle with cpu_wr_req or cpu_rd_req asserted
// S_WAIT_WR | controller busy with the write; down-counter runs to zero
// S_WAIT_RD | waiting for cpu_data_valid; up-counter bounds the wait
// S_DONE    | done/rdata/err presented to the granted requester for one cycle
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WR_CYCLES  = 2,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_done,
  output logic                  m0_err,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_done,
  output logic                  m1_err,

  output logic                  cpu_wr_req,
  output logic                  cpu_rd_req,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_data_valid,

  output logic                  busy,
  output logic                  gnt_id
);

  // Both WR_CYCLES and RD_TIMEOUT are limited to 255, so 8 bits cover either counter.
  localparam logic [7:0] WR_LOAD = 8'(WR_CYCLES - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_WR,
    S_WAIT_RD,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic                    we_q;
  logic                    gnt_q;
  logic                    last_q;
  logic                    busy_q;
  logic                    cpu_wr_req_q;
  logic                    cpu_rd_req_q;
  logic [ADDR_WIDTH-1:0]   cpu_addr_q;
  logic [DATA_WIDTH-1:0]   cpu_data_in_q;
  logic                    m0_done_q;
  logic                    m1_done_q;
  logic                    m0_err_q;
  logic                    m1_err_q;
  logic [DATA_WIDTH-1:0]   m0_rdata_q;
  logic [DATA_WIDTH-1:0]   m1_rdata_q;

  logic                    grant_d;
  logic                    sel_we_d;
  logic [ADDR_WIDTH-1:0]   sel_addr_d;
  logic [DATA_WIDTH-1:0]   sel_wdata_d;
  logic                    fin_d;
  logic                    fin_err_d;
  logic [DATA_WIDTH-1:0]   fin_rdata_d;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_d = 1'b0;
    if (m0_req && m1_req) begin
      grant_d = ~last_q;
    end else if (m1_req) begin
      grant_d = 1'b1;
    end
    sel_we_d    = grant_d ? m1_we    : m0_we;
    sel_addr_d  = grant_d ? m1_addr  : m0_addr;
    sel_wdata_d = grant_d ? m1_wdata : m0_wdata;
  end

  // Completion of the wait phase; valid read data takes priority over the timeout.
  always_comb begin
    fin_d       = 1'b0;
    fin_err_d   = 1'b0;
    fin_rdata_d = '0;
    case (state_q)
      S_WAIT_WR: begin
        fin_d = (cnt_q == 8'd0);
      end
      S_WAIT_RD: begin
        if (cpu_data_valid) begin
          fin_d       = 1'b1;
          fin_rdata_d = cpu_data_out;
        end else if (cnt_q == RD_LAST) begin
          fin_d     = 1'b1;
          fin_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transaction sequencer with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      gnt_q         <= 1'b0;
      last_q        <= 1'b1;
      busy_q        <= 1'b0;
      cpu_wr_req_q  <= 1'b0;
      cpu_rd_req_q  <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_data_in_q <= '0;
      m0_done_q     <= 1'b0;
      m1_done_q     <= 1'b0;
      m0_err_q      <= 1'b0;
      m1_err_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      cpu_wr_req_q <= 1'b0;
      cpu_rd_req_q <= 1'b0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;

      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q         <= grant_d;
            we_q          <= sel_we_d;
            cpu_addr_q    <= sel_addr_d;
            cpu_data_in_q <= sel_wdata_d;
            cpu_wr_req_q  <= sel_we_d;
            cpu_rd_req_q  <= ~sel_we_d;
            busy_q        <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (we_q) begin
            cnt_q   <= WR_LOAD;
            state_q <= S_WAIT_WR;
          end else begin
            cnt_q   <= '0;
            state_q <= S_WAIT_RD;
          end
        end

        S_WAIT_WR, S_WAIT_RD: begin
          if (fin_d) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
            if (gnt_q) begin
              m1_done_q  <= 1'b1;
              m1_err_q   <= fin_err_d;
              m1_rdata_q <= fin_rdata_d;
            end else begin
              m0_done_q  <= 1'b1;
              m0_err_q   <= fin_err_d;
              m0_rdata_q <= fin_rdata_d;
            end
          end else if (state_q == S_WAIT_WR) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_DONE: begin
          last_q  <= gnt_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_wr_req  = cpu_wr_req_q;
  assign cpu_rd_req  = cpu_rd_req_q;
  assign cpu_addr    = cpu_addr_q;
  assign cpu_data_in = cpu_data_in_q;
  assign m0_done     = m0_done_q;
  assign m1_done     = m1_done_q;
  assign m0_err      = m0_err_q;
  assign m1_err      = m1_err_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign busy        = busy_q;
  assign gnt_id      = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int WRC = 2;
  localparam int RDT = 64;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    req_b;
  logic          we_b    [2];
  logic [AW-1:0] addr_b  [2];
  logic [DW-1:0] wdata_b [2];
  logic          cpu_data_valid;
  logic [DW-1:0] cpu_data_out;

  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_done, m1_done, m0_err, m1_err;
  logic          cpu_wr_req, cpu_rd_req, busy, gnt_id;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic [1:0]    done_v;

  assign done_v = {m1_done, m0_done};

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_CYCLES(WRC), .RD_TIMEOUT(RDT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(req_b[0]), .m0_we(we_b[0]), .m0_addr(addr_b[0]), .m0_wdata(wdata_b[0]),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(req_b[1]), .m1_we(we_b[1]), .m1_addr(addr_b[1]), .m1_wdata(wdata_b[1]),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .cpu_wr_req(cpu_wr_req), .cpu_rd_req(cpu_rd_req),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_data_valid(cpu_data_valid),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // stimulus knobs
  bit      rand_en  = 0;
  bit      stray_en = 0;
  bit      ctl_rand = 0;
  int      ctl_delay = 0;
  logic [DW-1:0] ctl_data = '0;
  int      vld_at = 0;
  logic [DW-1:0] vld_dat = '0;
  int      g_seq[$];

  // model state: one transaction timeline, t = edges since the grant edge
  logic    m_act, m_fin, m_g, m_last, m_we;
  int      m_t;
  logic [1:0]    e_done, e_err;
  logic [DW-1:0] e_rd0, e_rd1, e_din;
  logic [AW-1:0] e_addr;
  logic          e_wrreq, e_rdreq, e_busy, e_gnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_fin = 0; m_g = 0; m_last = 1; m_we = 0; m_t = 0;
    e_done = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0; e_din = '0; e_addr = '0;
    e_wrreq = 0; e_rdreq = 0; e_busy = 0; e_gnt = 0;
  endtask

  task automatic finish_txn(input logic [DW-1:0] d, input logic er);
    m_fin = 1;
    e_done[m_g] = 1'b1;
    e_err[m_g]  = er;
    if (m_g) e_rd1 = d; else e_rd0 = d;
  endtask

  // Grant at t=0, command visible t=0, write done at t=1+WRC, read done at the
  // first t>=2 with valid, or at t=RDT+1 with err; one idle edge after done.
  task automatic model_edge();
    e_done = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0; e_wrreq = 0; e_rdreq = 0;
    if (!m_act) begin
      if (req_b != 2'b00) begin
        m_g = (req_b == 2'b11) ? ~m_last : req_b[1];
        m_act = 1; m_fin = 0; m_t = 0;
        m_we = we_b[m_g]; e_addr = addr_b[m_g]; e_din = wdata_b[m_g];
        e_gnt = m_g; e_wrreq = m_we; e_rdreq = ~m_we;
      end
    end else if (m_fin) begin
      m_act = 0; m_fin = 0; m_last = m_g;
    end else begin
      m_t++;
      if (m_we) begin
        if (m_t == 1 + WRC) finish_txn('0, 1'b0);
      end else if (m_t >= 2) begin
        if (cpu_data_valid) finish_txn(cpu_data_out, 1'b0);
        else if (m_t == RDT + 1) finish_txn('0, 1'b1);
      end
    end
    e_busy = m_act;
  endtask

  task automatic compare();
    chk("m0_done", m0_done, e_done[0]);
    chk("m1_done", m1_done, e_done[1]);
    chk("m0_err", m0_err, e_err[0]);
    chk("m1_err", m1_err, e_err[1]);
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
    chk("cpu_wr_req", cpu_wr_req, e_wrreq);
    chk("cpu_rd_req", cpu_rd_req, e_rdreq);
    chk("busy", busy, e_busy);
    chk("gnt_id", gnt_id, e_gnt);
    if (e_wrreq || e_rdreq) begin
      chk("cpu_addr", cpu_addr, e_addr);
      chk("cpu_data_in", cpu_data_in, e_din);
    end
    if (!resetn) begin
      chk("rst_cpu_addr", cpu_addr, '0);
      chk("rst_cpu_data_in", cpu_data_in, '0);
    end
  endtask

  // Requesters and memory controller behaviour for the next edge.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (req_b[i] && done_v[i]) req_b[i] = 1'b0;
      if (rand_en && !req_b[i] && $urandom_range(0, 3) == 0) begin
        req_b[i]   = 1'b1;
        we_b[i]    = 1'($urandom_range(0, 1));
        addr_b[i]  = AW'($urandom);
        wdata_b[i] = $urandom;
      end
    end
    if (cpu_rd_req) begin
      int d;
      if (ctl_delay < 0) d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 72));
      else d = ctl_delay;
      vld_at  = (d == 0) ? 0 : cyc + d;
      vld_dat = ctl_rand ? DW'($urandom) : ctl_data;
    end
    if (vld_at != 0 && cyc + 1 == vld_at) begin
      cpu_data_valid = 1'b1; cpu_data_out = vld_dat;
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      cpu_data_valid = 1'b1; cpu_data_out = $urandom;
    end else begin
      cpu_data_valid = 1'b0; cpu_data_out = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!resetn) model_reset(); else model_edge();
    #2;
    drive();
    @(negedge clk);
    if (!resetn) model_reset();
    compare();
  endtask

  task automatic pulse_reset();
    #1 resetn = 1'b0;
    req_b = '0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rd_req", cpu_rd_req, 0);
    chk("async_rst_done", done_v, 0);
    chk("async_rst_gnt", gnt_id, 0);
    chk("async_rst_addr", cpu_addr, 0);
    step();
    #1 resetn = 1'b1;
  endtask

  // One transaction; k=0 is the grant edge when the arbiter starts idle.
  task automatic txn(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input int window, output int first, output logic [DW-1:0] rd,
                     output logic er, output int pulses);
    req_b[i] = 1'b1; we_b[i] = we; addr_b[i] = a; wdata_b[i] = wd;
    first = -1; pulses = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < window; k++) begin
      step();
      if (done_v[i]) begin
        pulses++;
        if (first < 0) begin
          first = k;
          rd = (i == 1) ? m1_rdata : m0_rdata;
          er = (i == 1) ? m1_err : m0_err;
        end
      end
    end
    req_b[i] = 1'b0;
  endtask

  task automatic collect(input int n);
    g_seq.delete();
    for (int k = 0; k < n; k++) begin
      step();
      if (cpu_wr_req || cpu_rd_req) g_seq.push_back(int'(gnt_id));
    end
  endtask

  initial begin
    int first, pulses, quiet;
    logic [DW-1:0] rd;
    logic er;

    req_b = '0;
    for (int i = 0; i < 2; i++) begin
      we_b[i] = 1'b0; addr_b[i] = '0; wdata_b[i] = '0;
    end
    cpu_data_valid = 1'b0; cpu_data_out = '0;
    model_reset();

    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);
    #1 resetn = 1'b1;
    step();

    // m0 write: command after grant edge, done three edges later
    req_b[0] = 1'b1; we_b[0] = 1'b1; addr_b[0] = 10'h005; wdata_b[0] = 32'hA5A50001;
    step();
    chk("w_cpu_wr_req", cpu_wr_req, 1);
    chk("w_cpu_rd_req", cpu_rd_req, 0);
    chk("w_cpu_addr", cpu_addr, 10'h005);
    chk("w_cpu_data_in", cpu_data_in, 32'hA5A50001);
    chk("w_gnt", gnt_id, 0);
    step(); step();
    chk("w_done_early", m0_done, 0);
    step();
    chk("w_done", m0_done, 1);
    chk("w_err", m0_err, 0);
    step();
    chk("w_idle_busy", busy, 0);

    // m1 read, data four cycles after the command
    ctl_delay = 4; ctl_rand = 0; ctl_data = 32'hA5A50001;
    txn(1, 1'b0, 10'h005, '0, 8, first, rd, er, pulses);
    chk("r_first", first, 4);
    chk("r_rdata", rd, 32'hA5A50001);
    chk("r_err", er, 0);
    chk("r_pulses", pulses, 1);

    // contention from reset: m0 first, then alternate
    pulse_reset();
    req_b = 2'b11; we_b[0] = 1'b1; we_b[1] = 1'b1; addr_b[0] = 10'h010; addr_b[1] = 10'h011;
    collect(12);
    chk("rr1_n", g_seq.size(), 2);
    if (g_seq.size() == 2) begin
      chk("rr1_a", g_seq[0], 0);
      chk("rr1_b", g_seq[1], 1);
    end
    req_b[0] = 1'b1;
    collect(6);
    chk("rr2_n", g_seq.size(), 1);
    if (g_seq.size() == 1) chk("rr2_a", g_seq[0], 0);
    req_b = 2'b11;
    collect(12);
    chk("rr3_n", g_seq.size(), 2);
    if (g_seq.size() == 2) begin
      chk("rr3_a", g_seq[0], 1);
      chk("rr3_b", g_seq[1], 0);
    end

    // read with no data ever: timeout, then a normal write
    ctl_delay = 0;
    txn(0, 1'b0, 10'h3FF, '0, RDT + 4, first, rd, er, pulses);
    chk("to_first", first, RDT + 1);
    chk("to_err", er, 1);
    chk("to_rdata", rd, 0);
    chk("to_pulses", pulses, 1);
    txn(1, 1'b1, 10'h020, 32'h0000_BEEF, 6, first, rd, er, pulses);
    chk("to_next_first", first, 1 + WRC);
    chk("to_next_err", er, 0);

    // reset during a read wait, stale data afterwards, then a fresh m1 read
    ctl_delay = 10; ctl_data = 32'h1234_5678;
    req_b[0] = 1'b1; we_b[0] = 1'b0; addr_b[0] = 10'h0AA;
    repeat (4) step();
    chk("rw_busy_before", busy, 1);
    pulse_reset();
    quiet = 0;
    repeat (12) begin
      step();
      if (done_v != 2'b00) quiet++;
    end
    chk("rw_no_done", quiet, 0);
    ctl_delay = 3; ctl_data = 32'h0BAD_F00D;
    txn(1, 1'b0, 10'h0AA, '0, 7, first, rd, er, pulses);
    chk("rw_new_first", first, 3);
    chk("rw_new_rdata", rd, 32'h0BAD_F00D);
    chk("rw_new_err", er, 0);

    // stray valid in idle and during a write
    stray_en = 1;
    quiet = 0;
    repeat (6) begin
      step();
      if (done_v != 2'b00) quiet++;
    end
    chk("stray_idle_done", quiet, 0);
    txn(0, 1'b1, 10'h055, 32'hCAFE_0001, 6, first, rd, er, pulses);
    chk("stray_w_first", first, 1 + WRC);
    chk("stray_w_rdata", rd, 0);
    chk("stray_w_pulses", pulses, 1);

    // randomized traffic with one reset in the middle
    rand_en = 1; ctl_delay = -1; ctl_rand = 1;
    repeat (1500) step();
    pulse_reset();
    repeat (1500) step();
    rand_en = 0;
    repeat (80) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
